nco_tone_scheduler: RTL and testbench
=====================================

Name: nco_tone_scheduler

Overview:
Sequences the phase-increment words driving the two DAC-path NCOs, so multi-tone or frequency-hop patterns play without rebuilding the design. Holds a small table of {phase inc A, phase inc B, dwell} entries. Steps through the table on the 125 MHz DAC clock and drives phi_inc_i of both NCO instances plus their clken. Configuration writes occur only while idle.

Parameters:
PHW, 32, phase-increment width (matches NCO phi_inc_i)
DEPTH, 8, number of table entries
IDXW, 3, index width, equals clog2(DEPTH)
DWELLW, 24, dwell counter width in clk cycles

Ports:
clk  in  1  DAC-domain clock (CLK_125)
areset  in  1  asynchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  IDXW  table entry to write
cfg_inc_a  in  PHW  phase increment for NCO A
cfg_inc_b  in  PHW  phase increment for NCO B
cfg_dwell  in  DWELLW  entry duration in cycles (0 treated as 1)
cfg_last  in  IDXW  index of last entry played (sampled at start)
loop_en  in  1  wrap to entry 0 after last entry, instead of finishing
start  in  1  begin playback (level, sampled each edge)
stop  in  1  abort playback
phi_inc_a  out  PHW  to NCO A phi_inc_i
phi_inc_b  out  PHW  to NCO B phi_inc_i
nco_clken  out  1  to both NCO clken
cur_idx  out  IDXW  entry currently driven
step_strobe  out  1  one-cycle pulse on each entry load
busy  out  1  high in PLAY
done  out  1  one-cycle pulse when playback ends
cfg_err  out  1  one-cycle pulse: cfg_we rejected because busy

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; table entries cleared to 0; dwell counter 0; latched last index 0.
- States: IDLE, PLAY, DONE.
- IDLE:
  - cfg_we writes entry cfg_addr in one cycle.
  - start=1 and stop=0 at edge E0: latch last_idx = min(cfg_last, DEPTH-1). Drive entry 0 onto phi_inc_a/b after E0. Set cur_idx=0, step_strobe=1, counter=max(dwell0,1)-1, nco_clken=1, busy=1. Go to PLAY.
  - start and stop both high: stop wins; stay IDLE.
  - A table write and start in the same cycle: the write lands first, and the start loads the updated entry 0.
- PLAY, each edge:
  - stop=1 has the highest priority: go to DONE.
  - Else if counter>0: decrement; outputs hold.
  - Else, at entry end:
    - if cur_idx<last_idx: load entry cur_idx+1 with no gap cycle.
    - if cur_idx=last_idx and loop_en=1 (sampled at this edge): load entry 0.
    - otherwise go to DONE.
  - Each load pulses step_strobe and reloads counter=max(dwell,1)-1.
  - Entry k is therefore visible for exactly max(dwell_k,1) cycles.
  - cfg_we in PLAY: table unchanged; cfg_err pulses the next cycle.
  - start in PLAY: ignored.
- DONE:
  - Lasts one cycle: done=1, phi_inc_a/b=0, nco_clken=0, busy=0, cur_idx=0.
  - Then go to IDLE; all outputs hold 0.
  - cfg_we in DONE is accepted.
- Single-entry table (last_idx=0) with loop_en=1: entry 0 reloads every max(dwell0,1) cycles and step_strobe pulses each time.
- Reset mid-PLAY: outputs drop to 0 immediately (async); the table is cleared.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset values: assert areset, then release -> all outputs 0, state IDLE; start with an untouched table -> phi_inc_a/b=0 for 1 cycle, then done pulses.
- Three-entry sequence: write {A=0x0CCCCCCD,B=0x40000000,D=4}, {0x1000,0x2000,1}, {0x5,0x6,0}; cfg_last=2, loop_en=0; pulse start -> entry0 for 4 cycles, entry1 for 1 cycle, entry2 for 1 cycle. Expect step_strobe ×3, then done on the 7th cycle after start with outputs 0.
- Loop and stop: same table, loop_en=1 -> cur_idx sequence 0,1,2,0 with entry0 again for 4 cycles. Assert stop during the second entry0 -> DONE next edge, outputs 0, done=1.
- Write while busy: cfg_we addr 1 during PLAY -> cfg_err pulses once, entry1 keeps 0x1000/0x2000 on its next play.
- Simultaneous start+stop in IDLE -> state stays IDLE, busy=0, no step_strobe.
- Reset mid-play: assert areset during entry1 -> phi_inc_a/b and nco_clken go to 0 without waiting for a clk edge. After release, start -> entry0 reads 0.

Source files
------------

// File: rtl/nco_tone_scheduler.sv
// ----------------------------------------------------------------------------
// nco_tone_scheduler
//
// Purpose:
//   Steps through a small table of {phase inc A, phase inc B, dwell} entries
//   on the DAC clock and drives the phase-increment inputs and clock enable
//   of the two DAC-path NCOs. This lets multi-tone or frequency-hop patterns
//   play without rebuilding the design. The table can only be written while
//   playback is not running.
//
// Ports:
//   clk          DAC-domain clock (125 MHz)
//   areset       asynchronous reset, active-high (synchronous release upstream)
//   cfg_we       table write strobe (accepted in IDLE/DONE, rejected in PLAY)
//   cfg_addr     table entry to write
//   cfg_inc_a    phase increment for NCO A
//   cfg_inc_b    phase increment for NCO B
//   cfg_dwell    entry duration in clk cycles (0 behaves as 1)
//   cfg_last     index of last entry played, sampled at start
//   loop_en      wrap to entry 0 after the last entry instead of finishing
//   start        begin playback (level, sampled every edge in IDLE)
//   stop         abort playback (wins over start)
//   phi_inc_a    to NCO A phi_inc_i
//   phi_inc_b    to NCO B phi_inc_i
//   nco_clken    to both NCO clken
//   cur_idx      table entry currently driven
//   step_strobe  one-cycle pulse on every entry load
//   busy         high while playing
//   done         one-cycle pulse when playback ends
//   cfg_err      one-cycle pulse when a write was rejected during playback
// ----------------------------------------------------------------------------
module nco_tone_scheduler #(
    parameter int PHW    = 32,
    parameter int DEPTH  = 8,
    parameter int IDXW   = 3,
    parameter int DWELLW = 24
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cfg_we,
    input  logic [IDXW-1:0]   cfg_addr,
    input  logic [PHW-1:0]    cfg_inc_a,
    input  logic [PHW-1:0]    cfg_inc_b,
    input  logic [DWELLW-1:0] cfg_dwell,
    input  logic [IDXW-1:0]   cfg_last,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic [PHW-1:0]    phi_inc_a,
    output logic [PHW-1:0]    phi_inc_b,
    output logic              nco_clken,
    output logic [IDXW-1:0]   cur_idx,
    output logic              step_strobe,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    localparam logic [IDXW:0] LAST_MAX = (IDXW+1)'(DEPTH - 1);

    state_t            state;
    logic [PHW-1:0]    tbl_a [DEPTH];
    logic [PHW-1:0]    tbl_b [DEPTH];
    logic [DWELLW-1:0] tbl_d [DEPTH];
    logic [DWELLW-1:0] dwell_cnt;
    logic [IDXW-1:0]   last_idx;

    // Counter reload value: an entry is visible for max(dwell,1) cycles.
    function automatic logic [DWELLW-1:0] dwell_reload(input logic [DWELLW-1:0] d);
        return (d == '0) ? '0 : d - DWELLW'(1);
    endfunction

    // Clamp the requested last index into the table range.
    function automatic logic [IDXW-1:0] clamp_last(input logic [IDXW-1:0] v);
        return ({1'b0, v} > LAST_MAX) ? LAST_MAX[IDXW-1:0] : v;
    endfunction

    logic              wr_en;
    logic              wr_hit0;
    logic [PHW-1:0]    e0_a;
    logic [PHW-1:0]    e0_b;
    logic [DWELLW-1:0] e0_d;
    logic              more_entries;
    logic [IDXW-1:0]   load_idx;

    always_comb begin
        wr_en        = cfg_we && (state != S_PLAY);
        // A write to entry 0 coinciding with start must be seen by that start.
        wr_hit0      = wr_en && (cfg_addr == '0);
        e0_a         = wr_hit0 ? cfg_inc_a : tbl_a[0];
        e0_b         = wr_hit0 ? cfg_inc_b : tbl_b[0];
        e0_d         = wr_hit0 ? cfg_dwell : tbl_d[0];
        more_entries = (cur_idx < last_idx);
        load_idx     = more_entries ? cur_idx + IDXW'(1) : '0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            phi_inc_a   <= '0;
            phi_inc_b   <= '0;
            nco_clken   <= 1'b0;
            cur_idx     <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            dwell_cnt   <= '0;
            last_idx    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_a[i] <= '0;
                tbl_b[i] <= '0;
                tbl_d[i] <= '0;
            end
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;

            if (wr_en) begin
                tbl_a[cfg_addr] <= cfg_inc_a;
                tbl_b[cfg_addr] <= cfg_inc_b;
                tbl_d[cfg_addr] <= cfg_dwell;
            end

            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        last_idx    <= clamp_last(cfg_last);
                        phi_inc_a   <= e0_a;
                        phi_inc_b   <= e0_b;
                        dwell_cnt   <= dwell_reload(e0_d);
                        cur_idx     <= '0;
                        step_strobe <= 1'b1;
                        nco_clken   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    cfg_err <= cfg_we;
                    if (stop || (dwell_cnt == '0 && !more_entries && !loop_en)) begin
                        phi_inc_a <= '0;
                        phi_inc_b <= '0;
                        nco_clken <= 1'b0;
                        busy      <= 1'b0;
                        cur_idx   <= '0;
                        dwell_cnt <= '0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELLW'(1);
                    end else begin
                        // Next entry, or wrap to entry 0, with no gap cycle.
                        phi_inc_a   <= tbl_a[load_idx];
                        phi_inc_b   <= tbl_b[load_idx];
                        dwell_cnt   <= dwell_reload(tbl_d[load_idx]);
                        cur_idx     <= load_idx;
                        step_strobe <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_tone_scheduler.sv
module tb_nco_tone_scheduler;

    localparam int PHW    = 32;
    localparam int DEPTH  = 8;
    localparam int IDXW   = 3;
    localparam int DWELLW = 24;

    logic              clk = 1'b0;
    logic              areset;
    logic              cfg_we;
    logic [IDXW-1:0]   cfg_addr;
    logic [PHW-1:0]    cfg_inc_a;
    logic [PHW-1:0]    cfg_inc_b;
    logic [DWELLW-1:0] cfg_dwell;
    logic [IDXW-1:0]   cfg_last;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic [PHW-1:0]    phi_inc_a;
    logic [PHW-1:0]    phi_inc_b;
    logic              nco_clken;
    logic [IDXW-1:0]   cur_idx;
    logic              step_strobe;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    nco_tone_scheduler #(.PHW(PHW), .DEPTH(DEPTH), .IDXW(IDXW), .DWELLW(DWELLW)) dut (
        .clk(clk), .areset(areset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_inc_a(cfg_inc_a), .cfg_inc_b(cfg_inc_b),
        .cfg_dwell(cfg_dwell), .cfg_last(cfg_last), .loop_en(loop_en),
        .start(start), .stop(stop),
        .phi_inc_a(phi_inc_a), .phi_inc_b(phi_inc_b), .nco_clken(nco_clken),
        .cur_idx(cur_idx), .step_strobe(step_strobe), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #4 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: {phi_a, phi_b, clken, idx, strobe, busy, done}
    task automatic chk_out(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic ek, input logic [IDXW-1:0] ei, input logic es,
                           input logic ebz, input logic ed);
        chk({tag, ".phi_a"}, phi_inc_a, ea);
        chk({tag, ".phi_b"}, phi_inc_b, eb);
        chk({tag, ".clken"}, 32'(nco_clken), 32'(ek));
        chk({tag, ".idx"},   32'(cur_idx), 32'(ei));
        chk({tag, ".strobe"}, 32'(step_strobe), 32'(es));
        chk({tag, ".busy"},  32'(busy), 32'(ebz));
        chk({tag, ".done"},  32'(done), 32'(ed));
    endtask

    task automatic wr(input logic [IDXW-1:0] a, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [DWELLW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_inc_a = ia; cfg_inc_b = ib; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        areset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_inc_a = '0; cfg_inc_b = '0;
        cfg_dwell = '0; cfg_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        tick(); tick();
        chk_out("rst_held", 0, 0, 0, 0, 0, 0, 0);
        areset = 1'b0;
        tick();
        chk_out("rst_rel", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rel.cfg_err", 32'(cfg_err), 0);

        // Untouched table: entry 0 is zero for one cycle, then done.
        cfg_last = 0; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("empty_e0", 0, 0, 1, 0, 1, 1, 0);
        tick();
        chk_out("empty_done", 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_out("empty_idle", 0, 0, 0, 0, 0, 0, 0);

        // Three-entry table, single pass.
        wr(0, 32'h0CCCCCCD, 32'h40000000, 4);
        wr(1, 32'h00001000, 32'h00002000, 1);
        wr(2, 32'h00000005, 32'h00000006, 0);
        cfg_last = 2; loop_en = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("seq_c1", 32'h0CCCCCCD, 32'h40000000, 1, 0, 1, 1, 0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk_out("seq_hold0", 32'h0CCCCCCD, 32'h40000000, 1, 0, 0, 1, 0);
        end
        tick();
        chk_out("seq_c5", 32'h1000, 32'h2000, 1, 1, 1, 1, 0);
        tick();
        chk_out("seq_c6", 32'h5, 32'h6, 1, 2, 1, 1, 0);
        tick();
        chk_out("seq_c7_done", 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_out("seq_idle", 0, 0, 0, 0, 0, 0, 0);

        // Loop, write while busy, then stop during the second pass of entry 0.
        loop_en = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("loop_c1", 32'h0CCCCCCD, 32'h40000000, 1, 0, 1, 1, 0);
        cfg_we = 1'b1; cfg_addr = 1; cfg_inc_a = 32'hDEAD; cfg_inc_b = 32'hBEEF; cfg_dwell = 9;
        tick(); cfg_we = 1'b0;
        chk("busy_wr.cfg_err", 32'(cfg_err), 1);
        tick();
        chk("busy_wr.cfg_err_clr", 32'(cfg_err), 0);
        tick();
        chk_out("loop_c4", 32'h0CCCCCCD, 32'h40000000, 1, 0, 0, 1, 0);
        tick();
        chk_out("loop_e1", 32'h1000, 32'h2000, 1, 1, 1, 1, 0);
        tick();
        chk_out("loop_e2", 32'h5, 32'h6, 1, 2, 1, 1, 0);
        tick();
        chk_out("loop_wrap", 32'h0CCCCCCD, 32'h40000000, 1, 0, 1, 1, 0);
        tick();
        chk_out("loop_wrap_hold", 32'h0CCCCCCD, 32'h40000000, 1, 0, 0, 1, 0);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk_out("stop_done", 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_out("stop_idle", 0, 0, 0, 0, 0, 0, 0);

        // Start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        tick(); tick();
        start = 1'b0; stop = 1'b0;
        chk_out("startstop", 0, 0, 0, 0, 0, 0, 0);

        // Write to entry 0 in the same cycle as start: start sees new entry.
        loop_en = 1'b0; cfg_last = 0; start = 1'b1;
        wr(0, 32'h77, 32'h88, 2);
        start = 1'b0;
        chk_out("wr_start", 32'h77, 32'h88, 1, 0, 1, 1, 0);
        tick();
        chk_out("wr_start_hold", 32'h77, 32'h88, 1, 0, 0, 1, 0);
        tick();
        chk_out("wr_start_done", 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Single-entry loop: entry 0 reloads every 2 cycles.
        loop_en = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("single_c1", 32'h77, 32'h88, 1, 0, 1, 1, 0);
        tick();
        chk_out("single_c2", 32'h77, 32'h88, 1, 0, 0, 1, 0);
        tick();
        chk_out("single_reload", 32'h77, 32'h88, 1, 0, 1, 1, 0);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk_out("single_stop", 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Reset in the middle of entry 1: outputs drop without a clock edge.
        loop_en = 1'b0; cfg_last = 2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk_out("mid_e1", 32'h1000, 32'h2000, 1, 1, 1, 1, 0);
        #1 areset = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        areset = 1'b0;
        cfg_last = 0; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("post_rst_e0", 0, 0, 1, 0, 1, 1, 0);
        tick();
        chk_out("post_rst_done", 0, 0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
